// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters for IF-stage redirect
//
// Purpose: zero-latency next-pc prediction for fetch, trained by the branch-resolving stage.
//          Also counts resolved control transfers and mispredictions with saturating counters.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   lookup_pc         IF-stage pc (combinational lookup)
//   pred_hit          valid entry with matching tag for lookup_pc
//   pred_taken        pred_hit and counter predicts taken
//   pred_target       stored target when pred_taken, else lookup_pc+4
//   upd_valid         one resolved branch/jump this cycle
//   upd_pc            pc of the resolved instruction
//   upd_taken         actual outcome
//   upd_target        actual taken target
//   upd_mispredict    resolving stage flushed for this instruction
//   stat_updates      saturating count of upd_valid cycles
//   stat_mispredicts  saturating count of upd_valid & upd_mispredict cycles
module branch_predictor #(
  parameter int         ENTRIES   = 16,
  parameter int         PC_W      = 32,
  parameter int         CNT_W     = 16,
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] stat_updates,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  // Instructions are word aligned; the byte-offset bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update is not visible yet.
  assign pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit && ctr_q[l_idx][1];
  assign pred_target = pred_taken ? target_q[l_idx] : lookup_pc + PC_W'(4);

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Tags and targets have no reset; valid gates them, so only valid and ctr are cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
          target_q[u_idx] <= upd_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever aliases into this index.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_ALLOC;
      end
      if (stat_updates != '1) stat_updates <= stat_updates + CNT_W'(1);
      if (upd_mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed table, random-vs-model and counter-saturation bench for branch_predictor
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [15:0] stat_updates, stat_mispredicts;

  logic        unused_p4_hit, unused_p4_taken;
  logic [31:0] unused_p4_target;
  logic [3:0]  s4_upd, s4_misp;

  branch_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(16), .CTR_ALLOC(2'b10)) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(4), .CTR_ALLOC(2'b10)) dut4 (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(unused_p4_hit), .pred_taken(unused_p4_taken), .pred_target(unused_p4_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_updates(s4_upd), .stat_mispredicts(s4_misp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: each slot remembers the pc/(4*ENTRIES) it was allocated for and an integer counter.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_upd, m_misp;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_upd  = 0;
    m_misp = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic misp);
    int i;
    i = slot(pc);
    if (m_valid[i] && m_tag[i] == tagof(pc)) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tagof(pc);
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
    m_upd++;
    if (misp) m_misp++;
  endtask

  // Called just after a falling edge; drives inputs, samples outputs, advances one cycle.
  task automatic step(input bit chk, input logic r, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg, input logic um,
                      output logic o_hit, output logic o_taken, output logic [31:0] o_tgt);
    int   i;
    logic eh, et;
    logic [31:0] etg;
    reset = r; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_mispredict = um;
    #1;
    o_hit = pred_hit; o_taken = pred_taken; o_tgt = pred_target;
    if (chk) begin
      i   = slot(lpc);
      eh  = m_valid[i] && (m_tag[i] == tagof(lpc));
      et  = eh && (m_ctr[i] >= 2);
      etg = et ? m_tgt[i] : lpc + 32'd4;
      check("model pred_hit", 32'(pred_hit), 32'(eh));
      check("model pred_taken", 32'(pred_taken), 32'(et));
      check("model pred_target", pred_target, etg);
      check("model stat_updates", 32'(stat_updates), (m_upd > 65535) ? 32'd65535 : 32'(m_upd));
      check("model stat_mispredicts", 32'(stat_mispredicts), (m_misp > 65535) ? 32'd65535 : 32'(m_misp));
    end
    @(posedge clk);
    if (r) model_reset();
    else if (uv) model_update(upc, ut, utg, um);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  typedef struct {
    logic        r;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        um;
    logic        eh;
    logic        et;
    logic [31:0] etg;
  } vec_t;

  vec_t        tbl [27];
  logic        oh, ot;
  logic [31:0] otg;

  initial begin
    // r, lookup, uv, upd_pc, taken, target, misp | exp hit, taken, target (sampled before the edge)
    tbl[0]  = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h44};
    tbl[1]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h44};
    tbl[2]  = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100};
    tbl[3]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100};
    tbl[4]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h44};
    tbl[5]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h44};
    tbl[6]  = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h44};
    tbl[7]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h44};
    tbl[8]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h44};
    tbl[9]  = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200};
    tbl[10] = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200};
    tbl[11] = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h200};
    tbl[12] = '{1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h200};
    tbl[13] = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h44};
    tbl[14] = '{1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h44};
    tbl[15] = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h44};
    tbl[16] = '{1'b0, 32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h300};
    tbl[17] = '{1'b0, 32'h80, 1'b1, 32'hC0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h300};
    tbl[18] = '{1'b0, 32'hC0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'hC4};
    tbl[19] = '{1'b0, 32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h300};
    tbl[20] = '{1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[22] = '{1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234};
    tbl[23] = '{1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 32'h300};
    tbl[24] = '{1'b0, 32'h80, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h84};
    tbl[25] = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h44};
    tbl[26] = '{1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};

    reset = 1'b1; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, oh, ot, otg);
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, oh, ot, otg);
    reset = 1'b0;
    #1;
    check("reset pred_hit", 32'(pred_hit), 32'd0);
    check("reset pred_taken", 32'(pred_taken), 32'd0);
    check("reset pred_target", pred_target, 32'h44);
    check("reset stat_updates", 32'(stat_updates), 32'd0);
    check("reset stat_mispredicts", 32'(stat_mispredicts), 32'd0);

    for (int i = 0; i < 27; i++) begin
      step(1'b1, tbl[i].r, tbl[i].lpc, tbl[i].uv, tbl[i].upc, tbl[i].ut,
           tbl[i].utg, tbl[i].um, oh, ot, otg);
      check($sformatf("tbl[%0d] pred_hit", i), 32'(oh), 32'(tbl[i].eh));
      check($sformatf("tbl[%0d] pred_taken", i), 32'(ot), 32'(tbl[i].et));
      check($sformatf("tbl[%0d] pred_target", i), otg, tbl[i].etg);
      if (i == 22) begin
        check("tbl stat_updates before reset", 32'(stat_updates), 32'd13);
        check("tbl stat_mispredicts before reset", 32'(stat_mispredicts), 32'd2);
      end
      if (i == 23) begin
        check("stat_updates after reset+update", 32'(stat_updates), 32'd0);
        check("stat_mispredicts after reset+update", 32'(stat_mispredicts), 32'd0);
      end
    end

    // Random traffic on a small pc pool so hits, aliasing and saturation all occur.
    for (int k = 0; k < 3000; k++) begin
      step(1'b1, ($urandom_range(0, 199) == 0), pick_pc(), ($urandom_range(0, 3) != 0),
           pick_pc(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFFFFFC,
           1'($urandom_range(0, 1)), oh, ot, otg);
    end

    // Narrow counters: 20 mispredicted updates saturate the 4-bit instance at 15.
    step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, oh, ot, otg);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, pick_pc(), 1'b1, pick_pc(), 1'($urandom_range(0, 1)),
           $urandom & 32'hFFFFFFFC, 1'b1, oh, ot, otg);
      if (k == 9) begin
        check("cnt4 stat_updates mid", 32'(s4_upd), 32'd10);
        check("cnt4 stat_mispredicts mid", 32'(s4_misp), 32'd10);
      end
    end
    check("cnt4 stat_updates saturated", 32'(s4_upd), 32'd15);
    check("cnt4 stat_mispredicts saturated", 32'(s4_misp), 32'd15);
    check("cnt16 stat_updates after 20", 32'(stat_updates), 32'd20);
    check("cnt16 stat_mispredicts after 20", 32'(stat_mispredicts), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
